// File: rtl/lsu_bus_seq_if.sv
// lsu_bus_seq_if: signal bundle between the execute stage, the load/store bus sequencer and the
// shared data bus.
//   master : sequencer view (takes requests and bus responses; drives the bus, write-back and
//            status outputs)
//   slave  : environment view (core + bus), the mirror image of master
// Signal names keep the sequencer's point of view (_i = into the sequencer).
interface lsu_bus_seq_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [4:0]  req_rd_i;
   logic        int_assert_i;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] err_addr_o;
   logic        busy_o;

   modport master (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
             req_rd_i, int_assert_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
      output req_ready_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, wb_valid_o, wb_rd_o,
             wb_data_o, done_o, err_o, err_addr_o, busy_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
             req_rd_i, int_assert_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
      input  req_ready_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, wb_valid_o, wb_rd_o,
             wb_data_o, done_o, err_o, err_addr_o, busy_o
   );
endinterface

// File: rtl/lsu_bus_seq.sv
// lsu_bus_seq: load/store bus sequencer. Accepts one memory operation at a time, runs the bus
// request/grant/response handshake, performs read-modify-write for sub-word stores, lane-extracts
// and extends load data, stalls the pipeline while busy and aborts hung transactions.
// Ports:
//   clk, rst_n  : core clock, asynchronous active-low reset
//   lsu.master  : request, bus, write-back and status signals (see lsu_bus_seq_if)
// Parameter:
//   TIMEOUT_CYC : cycles without progress in a non-idle state before a bus error (1..255)
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses raise err_o without
//                          touching the bus; otherwise they are silently aligned.
module lsu_bus_seq #(
   parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
   input logic           clk,
   input logic           rst_n,
   lsu_bus_seq_if.master lsu
);

   typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrWait} state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d, uns_q, uns_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;

   logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d, busy_q, busy_d;
   logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic        wb_valid_q, wb_valid_d, done_q, done_d, err_q, err_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d, err_addr_q, err_addr_d;

   logic        accept, misalign, timeout;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_data, merge_data;

   assign lsu.req_ready_o = (state_q == StIdle) && !lsu.int_assert_i;
   assign accept          = lsu.req_valid_i && lsu.req_ready_o;
   assign timeout         = (state_q != StIdle) && (cnt_q == TIMEOUT_CYC);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((lsu.req_size_i == 2'b01) && lsu.req_addr_i[0]) ||
                     (lsu.req_size_i[1] && (lsu.req_addr_i[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Lane extraction and extension for loads, lane merge for sub-word stores.
   always_comb begin
      lane_b     = 8'h00;
      lane_h     = addr_q[1] ? lsu.bus_rdata_i[31:16] : lsu.bus_rdata_i[15:0];
      merge_data = lsu.bus_rdata_i;
      case (addr_q[1:0])
         2'd0:    lane_b = lsu.bus_rdata_i[7:0];
         2'd1:    lane_b = lsu.bus_rdata_i[15:8];
         2'd2:    lane_b = lsu.bus_rdata_i[23:16];
         default: lane_b = lsu.bus_rdata_i[31:24];
      endcase
      if (size_q[1]) begin
         load_data = lsu.bus_rdata_i;
      end else if (size_q[0]) begin
         load_data = {{16{!uns_q && lane_h[15]}}, lane_h};
      end else begin
         load_data = {{24{!uns_q && lane_b[7]}}, lane_b};
      end
      if (size_q[0]) begin
         if (addr_q[1]) merge_data[31:16] = wdata_q[15:0];
         else           merge_data[15:0]  = wdata_q[15:0];
      end else begin
         case (addr_q[1:0])
            2'd0:    merge_data[7:0]   = wdata_q[7:0];
            2'd1:    merge_data[15:8]  = wdata_q[7:0];
            2'd2:    merge_data[23:16] = wdata_q[7:0];
            default: merge_data[31:24] = wdata_q[7:0];
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_addr_d  = err_addr_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               we_d    = lsu.req_we_i;
               size_d  = lsu.req_size_i;
               uns_d   = lsu.req_unsigned_i;
               addr_d  = lsu.req_addr_i;
               wdata_d = lsu.req_wdata_i;
               rd_d    = lsu.req_rd_i;
               if (misalign) begin
                  err_d      = 1'b1;
                  err_addr_d = lsu.req_addr_i;
               end else begin
                  bus_addr_d  = {lsu.req_addr_i[31:2], 2'b00};
                  bus_wdata_d = lsu.req_wdata_i;
                  // Only full-word stores skip the read half of the sequence.
                  state_d = (lsu.req_we_i && lsu.req_size_i[1]) ? StWrReq : StRdReq;
               end
            end
         end
         StRdReq: if (lsu.bus_gnt_i) state_d = StRdWait;
         StRdWait: begin
            if (lsu.bus_rvalid_i) begin
               if (we_q) begin
                  bus_wdata_d = merge_data;
                  state_d     = StWrReq;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
                  wb_data_d  = load_data;
                  done_d     = 1'b1;
                  state_d    = StIdle;
               end
            end
         end
         StWrReq: if (lsu.bus_gnt_i) state_d = StWrWait;
         StWrWait: begin
            if (lsu.bus_rvalid_i) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // A grant/response arriving in the timeout cycle still counts as progress.
      if (timeout && (state_d == state_q)) begin
         state_d    = StIdle;
         err_d      = 1'b1;
         err_addr_d = addr_q;
      end
      cnt_d     = ((state_d != state_q) || (state_q == StIdle)) ? 8'd0 : cnt_q + 8'd1;
      bus_req_d = (state_d == StRdReq) || (state_d == StWrReq);
      bus_we_d  = (state_d == StWrReq);
      busy_d    = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         rd_q        <= 5'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= 32'h0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_addr_q  <= 32'h0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_addr_q  <= err_addr_d;
         busy_q      <= busy_d;
      end
   end

   assign lsu.bus_req_o   = bus_req_q;
   assign lsu.bus_we_o    = bus_we_q;
   assign lsu.bus_addr_o  = bus_addr_q;
   assign lsu.bus_wdata_o = bus_wdata_q;
   assign lsu.wb_valid_o  = wb_valid_q;
   assign lsu.wb_rd_o     = wb_rd_q;
   assign lsu.wb_data_o   = wb_data_q;
   assign lsu.done_o      = done_q;
   assign lsu.err_o       = err_q;
   assign lsu.err_addr_o  = err_addr_q;
   assign lsu.busy_o      = busy_q;

endmodule

// File: tb/tb_lsu_bus_seq.sv
// tb_lsu_bus_seq: randomized bench for lsu_bus_seq. Each transaction is expanded into a
// cycle-by-cycle timeline of expected outputs derived from the bus delays the bench itself
// chooses; one negedge process compares the DUT against that timeline.
module tb_lsu_bus_seq;
   localparam logic [7:0] TO = 8'd8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   lsu_bus_seq_if lsu ();
   lsu_bus_seq #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .lsu(lsu));

   always #5 clk = ~clk;

   // Expected outputs for the current cycle.
   logic        chk_on = 1'b0;
   logic        ex_ready, ex_breq, ex_bwe, ex_busy, ex_wbv, ex_done, ex_err;
   logic [31:0] ex_baddr, ex_bwdata, ex_wbdata, ex_err_addr;
   logic [4:0]  ex_rd;
   // Pulses that appear in the cycle after the transaction's last event.
   logic        pend_wb = 1'b0, pend_done = 1'b0, pend_err = 1'b0;
   logic [31:0] pend_wb_data = 32'h0, pend_err_addr = 32'h0, err_addr_m = 32'h0;
   logic [4:0]  pend_rd = 5'd0;

   task automatic chk1(input string name, input logic act, input logic req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Load result from the spec rules: shift the addressed lane down, then extend.
   function automatic logic [31:0] ext(input logic [31:0] rd, input logic [1:0] sz,
                                       input logic uns, input logic [31:0] a);
      logic [31:0] sh;
      if (sz[1]) return rd;
      if (sz == 2'b00) begin
         sh = rd >> (8 * a[1:0]);
         return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      sh = rd >> (16 * a[1]);
      return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
   endfunction

   // Sub-word store merge by mask.
   function automatic logic [31:0] mrg(input logic [31:0] rd, input logic [1:0] sz,
                                       input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] m, d;
      if (sz == 2'b00) begin
         m = 32'h0000_00FF << (8 * a[1:0]);
         d = {4{wd[7:0]}};
      end else begin
         m = 32'h0000_FFFF << (16 * a[1]);
         d = {2{wd[15:0]}};
      end
      return (rd & ~m) | (d & m);
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk1("req_ready", lsu.req_ready_o, ex_ready);
         chk1("bus_req", lsu.bus_req_o, ex_breq);
         chk1("bus_we", lsu.bus_we_o, ex_bwe);
         chk1("busy", lsu.busy_o, ex_busy);
         chk1("wb_valid", lsu.wb_valid_o, ex_wbv);
         chk1("done", lsu.done_o, ex_done);
         chk1("err", lsu.err_o, ex_err);
         chk32("err_addr", lsu.err_addr_o, ex_err_addr);
         if (ex_breq) chk32("bus_addr", lsu.bus_addr_o, ex_baddr);
         if (ex_bwe) chk32("bus_wdata", lsu.bus_wdata_o, ex_bwdata);
         if (ex_wbv) begin
            chk32("wb_data", lsu.wb_data_o, ex_wbdata);
            chk32("wb_rd", 32'(lsu.wb_rd_o), 32'(ex_rd));
         end
      end
   end

   // Drive one cycle of stimulus and publish the expectations for it.
   task automatic step(input logic rv, input logic ia, input logic gnt, input logic rvld,
                       input logic [31:0] rdata, input logic ready, input logic breq,
                       input logic bwe, input logic busy, input logic [31:0] baddr,
                       input logic [31:0] bwdata);
      lsu.req_valid_i  = rv;
      lsu.int_assert_i = ia;
      lsu.bus_gnt_i    = gnt;
      lsu.bus_rvalid_i = rvld;
      lsu.bus_rdata_i  = rdata;
      ex_ready  = ready;
      ex_breq   = breq;
      ex_bwe    = bwe;
      ex_busy   = busy;
      ex_baddr  = baddr;
      ex_bwdata = bwdata;
      ex_wbv    = pend_wb;
      ex_wbdata = pend_wb_data;
      ex_rd     = pend_rd;
      ex_done   = pend_done;
      ex_err    = pend_err;
      if (pend_err) err_addr_m = pend_err_addr;
      ex_err_addr = err_addr_m;
      pend_wb   = 1'b0;
      pend_done = 1'b0;
      pend_err  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_req();
      lsu.req_we_i       = rbit();
      lsu.req_size_i     = 2'($urandom_range(0, 3));
      lsu.req_unsigned_i = rbit();
      lsu.req_addr_i     = $urandom;
      lsu.req_wdata_i    = $urandom;
      lsu.req_rd_i       = 5'($urandom);
   endtask

   // One request phase (grant after g cycles) and one wait phase (response after r cycles).
   task automatic bus_phase(input logic wr, input logic [31:0] baddr, input logic [31:0] bwdata,
                            input int g, input int r, input logic [31:0] rdata,
                            input logic [31:0] addr, output logic ok);
      ok = 1'b0;
      for (int i = 0; i <= int'(TO); i++) begin
         scramble_req();
         step(rbit(), rbit(), i == g, (i != g) && rbit(), $urandom,
              1'b0, 1'b1, wr, 1'b1, baddr, bwdata);
         if (i == g) break;
         if (i == int'(TO)) begin
            pend_err      = 1'b1;
            pend_err_addr = addr;
            return;
         end
      end
      for (int j = 0; j <= int'(TO); j++) begin
         scramble_req();
         step(rbit(), rbit(), rbit(), j == r, (j == r) ? rdata : $urandom,
              1'b0, 1'b0, 1'b0, 1'b1, baddr, bwdata);
         if (j == r) begin
            ok = 1'b1;
            return;
         end
         if (j == int'(TO)) begin
            pend_err      = 1'b1;
            pend_err_addr = addr;
            return;
         end
      end
   endtask

   task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata1, input int g1, input int r1, input int g2,
                          input int r2, input int gap);
      logic        ia, mis, ok;
      logic [31:0] al, merged;
      al = {addr[31:2], 2'b00};
      for (int k = 0; k < gap; k++) begin
         ia = rbit();
         scramble_req();
         // A request is only offered while an interrupt blocks it.
         step(ia, ia, rbit(), rbit(), $urandom, !ia, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      lsu.req_we_i       = we;
      lsu.req_size_i     = sz;
      lsu.req_unsigned_i = uns;
      lsu.req_addr_i     = addr;
      lsu.req_wdata_i    = wdata;
      lsu.req_rd_i       = rd;
      step(1'b1, 1'b0, rbit(), rbit(), $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      mis = ((sz == 2'b01) && addr[0]) || (sz[1] && (addr[1:0] != 2'b00));
`else
      mis = 1'b0;
`endif
      if (mis) begin
         pend_err      = 1'b1;
         pend_err_addr = addr;
         return;
      end
      if (we && sz[1]) begin
         bus_phase(1'b1, al, wdata, g2, r2, $urandom, addr, ok);
         if (ok) pend_done = 1'b1;
      end else begin
         bus_phase(1'b0, al, 32'h0, g1, r1, rdata1, addr, ok);
         if (ok && !we) begin
            pend_wb      = 1'b1;
            pend_wb_data = ext(rdata1, sz, uns, addr);
            pend_rd      = rd;
            pend_done    = 1'b1;
         end else if (ok) begin
            merged = mrg(rdata1, sz, addr, wdata);
            bus_phase(1'b1, al, merged, g2, r2, $urandom, addr, ok);
            if (ok) pend_done = 1'b1;
         end
      end
   endtask

   function automatic int pick_delay();
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r == 0) return int'(TO) + 1 + int'($urandom_range(0, 2));
      if (r == 1) return int'(TO);
      return int'($urandom_range(0, 3));
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_ready"}, lsu.req_ready_o, !lsu.int_assert_i);
      chk1({tag, "_bus_req"}, lsu.bus_req_o, 1'b0);
      chk1({tag, "_bus_we"}, lsu.bus_we_o, 1'b0);
      chk1({tag, "_busy"}, lsu.busy_o, 1'b0);
      chk1({tag, "_wb_valid"}, lsu.wb_valid_o, 1'b0);
      chk1({tag, "_done"}, lsu.done_o, 1'b0);
      chk1({tag, "_err"}, lsu.err_o, 1'b0);
      chk32({tag, "_bus_addr"}, lsu.bus_addr_o, 32'h0);
      chk32({tag, "_bus_wdata"}, lsu.bus_wdata_o, 32'h0);
      chk32({tag, "_wb_data"}, lsu.wb_data_o, 32'h0);
      chk32({tag, "_wb_rd"}, 32'(lsu.wb_rd_o), 32'h0);
      chk32({tag, "_err_addr"}, lsu.err_addr_o, 32'h0);
   endtask

   initial begin
      lsu.req_valid_i    = 1'b0;
      lsu.req_we_i       = 1'b0;
      lsu.req_size_i     = 2'b00;
      lsu.req_unsigned_i = 1'b0;
      lsu.req_addr_i     = 32'h0;
      lsu.req_wdata_i    = 32'h0;
      lsu.req_rd_i       = 5'd0;
      lsu.int_assert_i   = 1'b0;
      lsu.bus_gnt_i      = 1'b0;
      lsu.bus_rvalid_i   = 1'b0;
      lsu.bus_rdata_i    = 32'h0;

      // Hand-computed anchors for the reference functions.
      chk32("pin_lb_1003", ext(32'h80FF_1234, 2'b00, 1'b0, 32'h1003), 32'hFFFF_FF80);
      chk32("pin_lhu_1002", ext(32'h80FF_1234, 2'b01, 1'b1, 32'h1002), 32'h0000_80FF);
      chk32("pin_lh_1002", ext(32'h80FF_1234, 2'b01, 1'b0, 32'h1002), 32'hFFFF_80FF);
      chk32("pin_sb_2001", mrg(32'h1122_3344, 2'b00, 32'h2001, 32'h0000_00AB), 32'h1122_AB44);
      chk32("pin_sh_2002", mrg(32'h1122_3344, 2'b01, 32'h2002, 32'h0000_BEEF), 32'hBEEF_3344);

      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // LB from 0x1003, zero-wait.
      run_txn(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd7, 32'h80FF_1234, 0, 0, 0, 0, 0);
      // SB 0xAB to 0x2001, back-to-back with the previous done.
      run_txn(1'b1, 2'b00, 1'b0, 32'h2001, 32'h0000_00AB, 5'd0, 32'h1122_3344, 0, 0, 0, 0, 0);
      // Word store with the grant held off for 5 cycles.
      run_txn(1'b1, 2'b10, 1'b0, 32'h5008, 32'hDEAD_BEEF, 5'd0, 32'h0, 0, 0, 5, 0, 1);
      // Load that never gets a response: timeout.
      run_txn(1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 5'd3, 32'h0, 0, int'(TO) + 3, 0, 0, 0);
      // Interrupt blocks an offered request for a few cycles.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      // LW at 0x3002.
      run_txn(1'b0, 2'b10, 1'b0, 32'h3002, 32'h0, 5'd9, 32'hCAFE_F00D, 1, 1, 0, 0, 0);
      // Signed half from the upper lane; grant on the last cycle before timeout.
      run_txn(1'b0, 2'b01, 1'b0, 32'h7002, 32'h0, 5'd12, 32'h8001_0000, int'(TO), 0, 0, 0, 1);
      // Sub-word half store with the write response on the timeout boundary.
      run_txn(1'b1, 2'b01, 1'b0, 32'h8000, 32'h0000_5A5A, 5'd0, 32'hFFFF_FFFF, 0, 2, 1,
              int'(TO), 0);

      for (int n = 0; n < 200; n++) begin
         run_txn(rbit(), 2'($urandom_range(0, 3)), rbit(), $urandom, $urandom, 5'($urandom),
                 $urandom, pick_delay(), pick_delay(), pick_delay(), pick_delay(),
                 int'($urandom_range(0, 2)));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset asserted while waiting for read data.
      lsu.req_we_i   = 1'b0;
      lsu.req_size_i = 2'b10;
      lsu.req_addr_i = 32'h4000;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4000, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      chk_on = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      lsu.bus_rvalid_i = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs("rst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      chk1("post_rst_bus_req", lsu.bus_req_o, 1'b0);
      chk1("post_rst_done", lsu.done_o, 1'b0);
      chk1("post_rst_wb_valid", lsu.wb_valid_o, 1'b0);
      chk1("post_rst_busy", lsu.busy_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
